cam_pix_gen: RTL and testbench

- Synthesizable OV7670-style pixel-bus transmitter: the source end of the camera capture interface.
- Generates full frames of RGB444 test patterns with camera-accurate VSYNC/HREF framing, one byte per clock.
- Drives the capture path (`cam_top` pixel inputs) during bring-up and simulation in place of the physical sensor; its clock feeds the receiver's pclk.

---
 rtl/cam_pix_gen.sv | 230 +++++++++++++++++++++++
 tb/tb_cam_pix_gen.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/cam_pix_gen.sv
// OV7670-style pixel-bus source: RGB444 test-pattern frames with VSYNC/HREF framing, one byte per clock.
// Optional CAM_GEN_FRAME_TAG_EN replaces the first pixel of active line 0 with a 16-bit frame count.
module cam_pix_gen #(
  parameter int H_ACTIVE    = 640,
  parameter int H_BLANK     = 144,
  parameter int V_ACTIVE    = 480,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 17,
  parameter int V_FRONT     = 10
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_stop,
  input  logic [1:0] i_pattern,
  output logic       o_vsync,
  output logic       o_href,
  output logic [7:0] o_pix_byte,
  output logic       o_busy,
  output logic       o_frame_done
);

  localparam int LB         = 2 * (H_ACTIVE + H_BLANK);
  localparam int HREF_BYTES = 2 * H_ACTIVE;
  localparam int BAR_PIX    = H_ACTIVE / 8;
  localparam int BYTE_W     = $clog2(LB);
  localparam int LINE_W     = $clog2(VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT + 1);
  localparam int SUB_W      = $clog2(BAR_PIX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_VSYNC,
    S_VBACK,
    S_ACTIVE,
    S_VFRONT
  } state_t;

  state_t              state_reg, state_next;
  logic [BYTE_W-1:0]   byte_cnt_reg, byte_cnt_next;
  logic [LINE_W-1:0]   line_cnt_reg, line_cnt_next;
  logic [SUB_W-1:0]    bar_sub_reg, bar_sub_next;
  logic [2:0]          bar_idx_reg, bar_idx_next;
  logic [1:0]          pattern_reg, pattern_next;
  logic                stop_pend_reg, stop_pend_next;

  logic                vsync_reg, href_reg, busy_reg, frame_done_reg;
  logic [7:0]          pix_byte_reg;

  logic [LINE_W-1:0]   state_lines;
  logic                byte_last, line_last, frame_end, stop_eff;
  logic                href_now;
  logic [9:0]          pix_x;
  logic [8:0]          pix_y;
  logic [11:0]         rgb;
  logic [7:0]          byte_now;
  logic                unused_pix_bits;

`ifdef CAM_GEN_FRAME_TAG_EN
  logic [15:0]         frame_cnt_reg;
`endif

  // Line count of the current vertical region
  always_comb begin
    state_lines = LINE_W'(1);
    case (state_reg)
      S_VSYNC:  state_lines = LINE_W'(VSYNC_LINES);
      S_VBACK:  state_lines = LINE_W'(V_BACK);
      S_ACTIVE: state_lines = LINE_W'(V_ACTIVE);
      S_VFRONT: state_lines = LINE_W'(V_FRONT);
      default:  state_lines = LINE_W'(1);
    endcase
  end

  assign byte_last = (byte_cnt_reg == BYTE_W'(LB - 1));
  assign line_last = (line_cnt_reg == state_lines - LINE_W'(1));
  assign frame_end = (state_reg == S_VFRONT) && line_last && byte_last;
  // Stop wins over a simultaneous start
  assign stop_eff  = i_stop | (stop_pend_reg & ~i_start);

  always_comb begin
    state_next     = state_reg;
    byte_cnt_next  = byte_cnt_reg;
    line_cnt_next  = line_cnt_reg;
    pattern_next   = pattern_reg;
    stop_pend_next = stop_pend_reg;
    case (state_reg)
      S_IDLE: begin
        byte_cnt_next = '0;
        line_cnt_next = '0;
        if (i_start) begin
          state_next     = S_VSYNC;
          pattern_next   = i_pattern;
          stop_pend_next = i_stop;
        end
      end
      default: begin
        stop_pend_next = stop_eff;
        byte_cnt_next  = byte_last ? '0 : byte_cnt_reg + 1'b1;
        if (byte_last) begin
          line_cnt_next = line_last ? '0 : line_cnt_reg + 1'b1;
        end
        if (byte_last && line_last) begin
          case (state_reg)
            S_VSYNC:  state_next = S_VBACK;
            S_VBACK:  state_next = S_ACTIVE;
            S_ACTIVE: state_next = S_VFRONT;
            default: begin
              if (stop_eff) begin
                state_next     = S_IDLE;
                stop_pend_next = 1'b0;
              end else begin
                state_next   = S_VSYNC;
                pattern_next = i_pattern;
              end
            end
          endcase
        end
      end
    endcase
  end

  // Bar index advances every BAR_PIX pixels on the second byte of each pixel
  always_comb begin
    bar_sub_next = bar_sub_reg;
    bar_idx_next = bar_idx_reg;
    if (byte_last || state_reg == S_IDLE) begin
      bar_sub_next = '0;
      bar_idx_next = '0;
    end else if (byte_cnt_reg[0] && byte_cnt_reg < BYTE_W'(HREF_BYTES)) begin
      if (bar_sub_reg == SUB_W'(BAR_PIX - 1)) begin
        bar_sub_next = '0;
        bar_idx_next = bar_idx_reg + 3'd1;
      end else begin
        bar_sub_next = bar_sub_reg + 1'b1;
      end
    end
  end

  assign href_now = (state_reg == S_ACTIVE) && (byte_cnt_reg < BYTE_W'(HREF_BYTES));
  assign pix_x    = 10'(byte_cnt_reg >> 1);
  assign pix_y    = 9'(line_cnt_reg);
  assign unused_pix_bits = ^{pix_x[4], pix_y[4:0]};

  always_comb begin
    rgb = 12'h000;
    case (pattern_reg)
      2'd0: begin
        case (bar_idx_reg)
          3'd0:    rgb = 12'hFFF;
          3'd1:    rgb = 12'hFF0;
          3'd2:    rgb = 12'h0FF;
          3'd3:    rgb = 12'h0F0;
          3'd4:    rgb = 12'hF0F;
          3'd5:    rgb = 12'hF00;
          3'd6:    rgb = 12'h00F;
          default: rgb = 12'h000;
        endcase
      end
      2'd1:    rgb = {pix_x[9:6], pix_y[8:5], pix_x[3:0]};
      2'd2:    rgb = (pix_x[5] ^ pix_y[5]) ? 12'hFFF : 12'h000;
      default: rgb = 12'h888;
    endcase
  end

  always_comb begin
    byte_now = 8'h00;
    if (href_now) begin
      byte_now = byte_cnt_reg[0] ? rgb[7:0] : {4'h0, rgb[11:8]};
`ifdef CAM_GEN_FRAME_TAG_EN
      if (line_cnt_reg == '0 && byte_cnt_reg < BYTE_W'(2)) begin
        byte_now = byte_cnt_reg[0] ? frame_cnt_reg[7:0] : frame_cnt_reg[15:8];
      end
`endif
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg     <= S_IDLE;
      byte_cnt_reg  <= '0;
      line_cnt_reg  <= '0;
      bar_sub_reg   <= '0;
      bar_idx_reg   <= '0;
      pattern_reg   <= '0;
      stop_pend_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      byte_cnt_reg  <= byte_cnt_next;
      line_cnt_reg  <= line_cnt_next;
      bar_sub_reg   <= bar_sub_next;
      bar_idx_reg   <= bar_idx_next;
      pattern_reg   <= pattern_next;
      stop_pend_reg <= stop_pend_next;
    end
  end

`ifdef CAM_GEN_FRAME_TAG_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      frame_cnt_reg <= '0;
    end else if (frame_end) begin
      frame_cnt_reg <= frame_cnt_reg + 16'd1;
    end
  end
`endif

  // Output stage: every output is a flop fed from the current state and counters
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vsync_reg      <= 1'b0;
      href_reg       <= 1'b0;
      pix_byte_reg   <= 8'h00;
      busy_reg       <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      vsync_reg      <= (state_reg == S_VSYNC);
      href_reg       <= href_now;
      pix_byte_reg   <= byte_now;
      busy_reg       <= (state_reg != S_IDLE);
      frame_done_reg <= frame_end;
    end
  end

  assign o_vsync      = vsync_reg;
  assign o_href       = href_reg;
  assign o_pix_byte   = pix_byte_reg;
  assign o_busy       = busy_reg;
  assign o_frame_done = frame_done_reg;

endmodule

// File: tb/tb_cam_pix_gen.sv
// Scoreboard bench for cam_pix_gen: a frame-position reference model queues expected outputs,
// a negedge monitor pops and compares them against the DUT every clock.
module tb_cam_pix_gen;

  localparam int HA = 8, HB = 2, VA = 4, VS = 1, VB = 1, VF = 1;
  localparam int LB = 2 * (HA + HB);
  localparam int FRAME = (VS + VB + VA + VF) * LB;
`ifdef CAM_GEN_FRAME_TAG_EN
  localparam bit TAG_EN = 1'b1;
`else
  localparam bit TAG_EN = 1'b0;
`endif
  localparam logic [11:0] BARS [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                       12'hF0F, 12'hF00, 12'h00F, 12'h000};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [1:0] pattern = 2'd0;
  logic       vsync, href, busy, frame_done;
  logic [7:0] pix_byte;
  bit         seq_done = 1'b0;

  always #5 clk = ~clk;

  cam_pix_gen #(
    .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA),
    .VSYNC_LINES(VS), .V_BACK(VB), .V_FRONT(VF)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop), .i_pattern(pattern),
    .o_vsync(vsync), .o_href(href), .o_pix_byte(pix_byte),
    .o_busy(busy), .o_frame_done(frame_done)
  );

  typedef struct packed {
    logic       vsync;
    logic       href;
    logic [7:0] pix;
    logic       busy;
    logic       done;
  } out_t;

  out_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   frames = 0;

  // Reference model: whether a frame is running, position inside it, and frame-level flags
  bit         m_run = 1'b0;
  int         m_k = 0;
  bit         m_pend = 1'b0;
  logic [1:0] m_pat = 2'd0;
  int         m_fcnt = 0;

  function automatic logic [11:0] color(input logic [1:0] pat, input int x, input int y);
    case (pat)
      2'd0:    return BARS[x / (HA / 8)];
      2'd1:    return 12'(((x >> 6) & 15) * 256 + ((y >> 5) & 15) * 16 + (x & 15));
      2'd2:    return ((((x >> 5) ^ (y >> 5)) & 1) != 0) ? 12'hFFF : 12'h000;
      default: return 12'h888;
    endcase
  endfunction

  function automatic out_t model_out();
    out_t        o;
    int          line, b, x, y;
    logic [11:0] c;
    logic [15:0] tag;
    o = '0;
    if (m_run) begin
      line    = m_k / LB;
      b       = m_k % LB;
      o.busy  = 1'b1;
      o.vsync = (line < VS);
      o.href  = (line >= VS + VB) && (line < VS + VB + VA) && (b < 2 * HA);
      o.done  = (m_k == FRAME - 1);
      if (o.href) begin
        x = b / 2;
        y = line - VS - VB;
        c = color(m_pat, x, y);
        o.pix = (b % 2 == 0) ? {4'h0, c[11:8]} : c[7:0];
        if (TAG_EN && x == 0 && y == 0) begin
          tag   = 16'(m_fcnt);
          o.pix = (b == 0) ? tag[15:8] : tag[7:0];
        end
      end
    end
    return o;
  endfunction

  // Model step: expected output for the coming cycle is queued, then inputs are applied
  initial begin
    forever begin
      @(posedge clk);
      exp_q.push_back(rst ? out_t'('0) : model_out());
      if (rst) begin
        m_run = 1'b0; m_k = 0; m_pend = 1'b0; m_fcnt = 0;
      end else if (!m_run) begin
        if (start) begin
          m_run = 1'b1; m_k = 0; m_pend = stop; m_pat = pattern;
        end
      end else begin
        if (stop) m_pend = 1'b1;
        else if (start) m_pend = 1'b0;
        if (m_k == FRAME - 1) begin
          m_fcnt = (m_fcnt + 1) & 16'hFFFF;
          if (m_pend) begin
            m_run = 1'b0; m_pend = 1'b0;
          end else begin
            m_k = 0; m_pat = pattern;
          end
        end else begin
          m_k = m_k + 1;
        end
      end
    end
  end

  // Monitor
  initial begin
    out_t e, a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '{vsync: vsync, href: href, pix: pix_byte, busy: busy, done: frame_done};
        tests++;
        if (a !== e) begin
          fails++;
          $display("FAIL out_cmp t=%0t got(vs=%b hr=%b pix=%02h busy=%b done=%b) want(vs=%b hr=%b pix=%02h busy=%b done=%b)",
                   $time, a.vsync, a.href, a.pix, a.busy, a.done,
                   e.vsync, e.href, e.pix, e.busy, e.done);
        end
        if (e.done) begin
          frames++;
          $display("[TB] frame %0d complete t=%0t", frames, $time);
        end
      end
    end
  end

  // Watchdog: the stimulus sequence must finish within a bounded time
  initial begin
    #2000000;
    if (!seq_done) begin
      fails++;
      $display("FAIL timeout t=%0t stimulus sequence did not complete", $time);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
    end
  end

  task automatic check_idle(input string tag);
    tests++;
    if (vsync !== 1'b0 || href !== 1'b0 || pix_byte !== 8'h00 || busy !== 1'b0 || frame_done !== 1'b0) begin
      fails++;
      $display("FAIL idle_state %s t=%0t vs=%b hr=%b pix=%02h busy=%b done=%b",
               tag, $time, vsync, href, pix_byte, busy, frame_done);
    end else begin
      $display("[TB] idle_state %s ok t=%0t", tag, $time);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input bit s, input bit p);
    start = s;
    stop  = p;
    cycles(1);
    start = 1'b0;
    stop  = 1'b0;
  endtask

  initial begin
    cycles(3);
    rst = 1'b0;
    cycles(200);                          // idle, no start
    check_idle("after_reset");

    pattern = 2'd0; pulse(1, 0);          // bars, continuous
    cycles(200);
    pulse(0, 1);                          // stop inside frame 2 ACTIVE
    cycles(200);

    pattern = 2'd2; pulse(1, 0);          // checker, switched to grey mid-frame
    cycles(70);
    pattern = 2'd3;
    cycles(130);
    pulse(0, 1);
    cycles(200);

    pattern = 2'd1; pulse(1, 0);          // ramp, reset during HREF
    cycles(50);
    rst = 1'b1; cycles(1); rst = 1'b0;
    cycles(20);
    pulse(1, 0);
    cycles(300);
    pulse(1, 1);                          // stop wins over start while busy
    cycles(300);

    pulse(0, 1);                          // stop alone in idle is ignored
    cycles(20);
    pulse(1, 1);                          // start+stop in idle: single frame
    cycles(300);
    check_idle("after_single_frame");

    for (int i = 0; i < 4000; i++) begin
      start = ($urandom_range(0, 99) == 0);
      stop  = ($urandom_range(0, 149) == 0);
      rst   = ($urandom_range(0, 999) == 0);
      if ($urandom_range(0, 49) == 0) pattern = 2'($urandom_range(0, 3));
      cycles(1);
    end
    start = 1'b0; rst = 1'b0;
    pulse(0, 1);
    cycles(2 * FRAME);
    @(negedge clk);
    #1;
    seq_done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
